ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host FSM state encoding, default timing
// parameters and the frame parity helper. The receiver imports this too.
package ps2_pkg;

   // 100 us of clock inhibit at 50 MHz before the host requests to send.
   localparam int PS2_INHIBIT_CYC = 5000;
   // 20 ms at 50 MHz from clock release until the bus must be idle again.
   localparam int PS2_TIMEOUT_CYC = 1000000;
   // Data byte plus odd parity, shifted out LSB first.
   localparam int PS2_FRAME_BITS  = 9;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_state_t;

   // Odd parity: the bit that makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer plus falling-edge detector for W raw PS/2 lines.
// Lines idle high, so every stage resets to 1 to avoid a false edge.
module ps2_sync #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] sync,
   output logic [W-1:0] fe
);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_ch
         logic meta_reg;
         logic sync_reg;
         logic prev_reg;

         // Two metastability stages, then one more stage to remember the previous value.
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
               prev_reg <= 1'b1;
            end else begin
               meta_reg <= raw[gi];
               sync_reg <= meta_reg;
               prev_reg <= sync_reg;
            end
         end

         assign sync[gi] = sync_reg;
         assign fe[gi]   = prev_reg & ~sync_reg;
      end
   endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the clock, asserts the
// start bit, then shifts {parity, din} out on device-generated falling edges,
// checks the device acknowledge and waits for the bus to return to idle.
// The pads are open drain: *_oe = 1 pulls the line low.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
   parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_c,
   input  logic        ps2_d,
   output logic        ps2_c_oe,
   output logic        ps2_d_oe,
   input  logic        wr,
   input  logic [7:0]  din,
   output logic        busy,
   output logic [31:0] status
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
   localparam logic [3:0]       LAST_DATA_FE = 4'(PS2_FRAME_BITS);

   ps2_state_t  state_reg, state_next;
   logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [3:0]  bit_cnt_reg, bit_cnt_next;
   logic [PS2_FRAME_BITS-1:0] frame_reg, frame_next;
   logic        d_drive_reg, d_drive_next;
   logic        done_reg, done_next;
   logic        err_reg, err_next;

   logic [1:0]  sync_w;
   logic [1:0]  fe_w;
   logic        c_sync, d_sync, c_fe;
   logic        unused_d_fe;
   logic        tmo_active, tmo_hit;

   ps2_sync #(.W(2)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  ({ps2_d, ps2_c}),
      .sync (sync_w),
      .fe   (fe_w)
   );

   assign c_sync      = sync_w[0];
   assign d_sync      = sync_w[1];
   assign c_fe        = fe_w[0];
   // Only clock edges pace the transmitter; data edges are not needed here.
   assign unused_d_fe = fe_w[1];

   // The timeout window opens at clock release and covers every bus phase after it.
   assign tmo_active = (state_reg == REQ) || (state_reg == SEND) ||
                       (state_reg == ACK) || (state_reg == WAIT_IDLE);
   assign tmo_hit    = tmo_active && (tmo_cnt_reg == TMO_LAST);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         inh_cnt_reg <= '0;
         tmo_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         frame_reg   <= '0;
         d_drive_reg <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         inh_cnt_reg <= inh_cnt_next;
         tmo_cnt_reg <= tmo_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         frame_reg   <= frame_next;
         d_drive_reg <= d_drive_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
      end
   end

   // Next-state logic; a timeout overrides anything the bus did this cycle.
   always_comb begin
      state_next   = state_reg;
      inh_cnt_next = inh_cnt_reg;
      tmo_cnt_next = tmo_active ? tmo_cnt_reg + 1'b1 : '0;
      bit_cnt_next = bit_cnt_reg;
      frame_next   = frame_reg;
      d_drive_next = d_drive_reg;
      done_next    = done_reg;
      err_next     = err_reg;

      case (state_reg)
         IDLE: begin
            if (wr) begin
               frame_next   = {odd_parity(din), din};
               done_next    = 1'b0;
               err_next     = 1'b0;
               inh_cnt_next = '0;
               state_next   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt_reg == INH_LAST) begin
               inh_cnt_next = '0;
               state_next   = REQ;
            end else begin
               inh_cnt_next = inh_cnt_reg + 1'b1;
            end
         end
         REQ: begin
            // Start bit stays asserted until the device's first falling edge.
            d_drive_next = 1'b1;
            bit_cnt_next = '0;
            state_next   = SEND;
         end
         SEND: begin
            if (c_fe) begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg < LAST_DATA_FE) begin
                  d_drive_next = ~frame_reg[bit_cnt_reg];
               end else begin
                  // Tenth edge: release data so the device reads the stop bit as 1.
                  d_drive_next = 1'b0;
                  state_next   = ACK;
               end
            end
         end
         ACK: begin
            if (c_fe) begin
               if (d_sync) begin
                  err_next = 1'b1;
               end
               state_next = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (c_sync && d_sync) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (tmo_hit) begin
         state_next   = IDLE;
         tmo_cnt_next = '0;
         bit_cnt_next = '0;
         d_drive_next = 1'b0;
         done_next    = 1'b1;
         err_next     = 1'b1;
      end
   end

   // Pad enables decode from registered state so they are glitch free.
   always_comb begin
      ps2_c_oe = (state_reg == INHIBIT);
      ps2_d_oe = ((state_reg == INHIBIT) && (inh_cnt_reg == INH_LAST)) ||
                 (state_reg == REQ) ||
                 ((state_reg == SEND) && d_drive_reg);
   end

   assign busy   = (state_reg != IDLE);
   assign status = {29'b0, err_reg, done_reg, busy};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on an open-drain bus,
// with expected frames computed from byte value and parity rules.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH = 5000;
   localparam int TMO = 3000;
   localparam int HP  = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr;
   logic [7:0]  din;
   logic        ps2_c_oe, ps2_d_oe, busy;
   logic [31:0] status;
   logic        ps2_c_bus, ps2_d_bus;

   logic        dev_c_low = 1'b0;
   logic        dev_d_low = 1'b0;
   int          dev_mode  = 0;      // 0 = acknowledge, 1 = no acknowledge, 2 = silent
   logic        dev_busy  = 1'b0;
   int          dev_pulses = 0;
   logic [9:0]  dev_bits = '0;
   logic        dev_start = 1'b1;

   int total = 0;
   int bad   = 0;

   assign ps2_c_bus = ~(ps2_c_oe | dev_c_low);
   assign ps2_d_bus = ~(ps2_d_oe | dev_d_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_c    (ps2_c_bus),
      .ps2_d    (ps2_d_bus),
      .ps2_c_oe (ps2_c_oe),
      .ps2_d_oe (ps2_d_oe),
      .wr       (wr),
      .din      (din),
      .busy     (busy),
      .status   (status)
   );

   // What the device should read: 8 data bits LSB first, odd parity, stop = 1.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   // Device: on a host request, clocks 10 bits, then an acknowledge pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (dev_mode != 2 && !rst && ps2_c_bus && !ps2_d_bus) begin
            dev_busy   = 1'b1;
            dev_pulses = 0;
            repeat (HP) @(negedge clk);
            dev_start = ps2_d_bus;
            for (int k = 0; k < 10; k++) begin
               dev_c_low = 1'b1;
               dev_pulses++;
               repeat (HP) @(negedge clk);
               dev_c_low   = 1'b0;
               dev_bits[k] = ps2_d_bus;
               repeat (HP) @(negedge clk);
            end
            if (dev_mode == 0) dev_d_low = 1'b1;
            repeat (HP / 2) @(negedge clk);
            dev_c_low = 1'b1;
            dev_pulses++;
            repeat (HP) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HP) @(negedge clk);
            dev_d_low = 1'b0;
            dev_busy  = 1'b0;
         end
      end
   end

   // Pulse wr and measure how long the clock is inhibited and the start bit overlaps it.
   task automatic start_wr(input logic [7:0] b, output int c_len, output int d_len,
                           output logic busy_seen);
      @(negedge clk);
      wr  = 1'b1;
      din = b;
      @(negedge clk);
      wr        = 1'b0;
      din       = 8'($urandom);
      busy_seen = busy;
      c_len     = 0;
      d_len     = 0;
      for (int i = 0; i < INH + 50; i++) begin
         if (!ps2_c_oe) break;
         c_len++;
         if (ps2_d_oe) d_len++;
         @(negedge clk);
      end
   endtask

   // Wait for the host to go idle and the device to finish its frame.
   task automatic finish_frame(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3000 && dev_busy; i++) @(negedge clk);
      if (dev_busy) ok = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr  = 1'b0;
      din = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if (status !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=%h", status, 32'h0); end
      total++;
      if ({ps2_c_oe, ps2_d_oe, busy} !== 3'b000) begin
         bad++; $display("FAIL reset_oe got=%b want=000", {ps2_c_oe, ps2_d_oe, busy});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (status !== 32'h0) begin bad++; $display("FAIL idle_status got=%h want=%h", status, 32'h0); end
      $display("reset: status=%h", status);
   endtask

   // Full acknowledged transfer; checks inhibit timing, frame bits and final status.
   task automatic test_frame(input string name, input logic [7:0] b, input int mode);
      int c_len, d_len;
      logic bs, ok;
      logic [31:0] want;
      dev_mode = mode;
      start_wr(b, c_len, d_len, bs);
      total++;
      if (bs !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", name, bs); end
      total++;
      if (c_len !== INH) begin bad++; $display("FAIL %s_inhibit got=%0d want=%0d", name, c_len, INH); end
      total++;
      if (d_len !== 1) begin bad++; $display("FAIL %s_start_overlap got=%0d want=1", name, d_len); end
      total++;
      if ({ps2_c_oe, ps2_d_oe} !== 2'b01) begin
         bad++; $display("FAIL %s_req_oe got=%b want=01", name, {ps2_c_oe, ps2_d_oe});
      end
      finish_frame(ok);
      want = (mode == 1) ? 32'h6 : 32'h2;
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL %s_complete got=%b want=1", name, ok); end
      total++;
      if (dev_bits !== model_frame(b) || dev_start !== 1'b0) begin
         bad++; $display("FAIL %s_bits got=%b start=%b want=%b start=0", name, dev_bits, dev_start, model_frame(b));
      end
      total++;
      if (status !== want) begin bad++; $display("FAIL %s_status got=%h want=%h", name, status, want); end
      $display("%s: din=%h bits=%b status=%h inhibit=%0d", name, b, dev_bits, status, c_len);
   endtask

   task automatic test_timeout();
      int c_len, d_len;
      logic bs;
      dev_mode = 2;
      start_wr(8'hA5, c_len, d_len, bs);
      repeat (TMO) @(negedge clk);
      total++;
      if (status !== 32'h1) begin bad++; $display("FAIL timeout_early got=%h want=%h", status, 32'h1); end
      @(negedge clk);
      total++;
      if (status !== 32'h6) begin bad++; $display("FAIL timeout_status got=%h want=%h", status, 32'h6); end
      total++;
      if ({ps2_c_oe, ps2_d_oe} !== 2'b00) begin
         bad++; $display("FAIL timeout_oe got=%b want=00", {ps2_c_oe, ps2_d_oe});
      end
      $display("timeout: status=%h oe=%b", status, {ps2_c_oe, ps2_d_oe});
      dev_mode = 0;
   endtask

   task automatic test_wr_ignored();
      int c_len, d_len;
      logic bs, ok;
      dev_mode = 0;
      start_wr(8'h96, c_len, d_len, bs);
      for (int i = 0; i < 1000 && dev_pulses < 3; i++) @(negedge clk);
      wr  = 1'b1;
      din = 8'h00;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      total++;
      if (status !== 32'h1) begin bad++; $display("FAIL ignored_status got=%h want=%h", status, 32'h1); end
      finish_frame(ok);
      total++;
      if (ok !== 1'b1 || dev_bits !== model_frame(8'h96)) begin
         bad++; $display("FAIL ignored_bits got=%b ok=%b want=%b", dev_bits, ok, model_frame(8'h96));
      end
      total++;
      if (status !== 32'h2) begin bad++; $display("FAIL ignored_final got=%h want=%h", status, 32'h2); end
      $display("wr_ignored: bits=%b status=%h", dev_bits, status);
   endtask

   task automatic test_rst_mid();
      int c_len, d_len;
      logic bs;
      dev_mode = 0;
      start_wr(8'h3C, c_len, d_len, bs);
      for (int i = 0; i < 1000 && dev_pulses < 5; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (status !== 32'h0) begin bad++; $display("FAIL rst_mid_status got=%h want=%h", status, 32'h0); end
      total++;
      if ({ps2_c_oe, ps2_d_oe} !== 2'b00) begin
         bad++; $display("FAIL rst_mid_oe got=%b want=00", {ps2_c_oe, ps2_d_oe});
      end
      rst = 1'b0;
      $display("rst_mid: status=%h oe=%b", status, {ps2_c_oe, ps2_d_oe});
      for (int i = 0; i < 3000 && dev_busy; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      test_frame("after_rst", 8'h5A, 0);
   endtask

   task automatic test_random();
      logic [7:0] b;
      int mode;
      for (int n = 0; n < 3; n++) begin
         b    = 8'($urandom);
         mode = int'($urandom_range(0, 1));
         test_frame(mode == 1 ? "rand_nack" : "rand_ack", b, mode);
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      wr  = 1'b0;
      din = 8'h00;
      test_reset();
      test_frame("send_ed", 8'hED, 0);
      test_frame("parity_f4", 8'hF4, 0);
      test_frame("nack", 8'h81, 1);
      test_timeout();
      test_wr_ignored();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
